// File: rtl/alu_serial_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_serial_driver_pkg
// Brief  : Opcodes of the bit-serial ALU and driver FSM state encodings.
// Rev    : 1.0
// ============================================================================
package alu_serial_driver_pkg;

  localparam logic [2:0] c_op_add  = 3'd0;
  localparam logic [2:0] c_op_sub  = 3'd1;
  localparam logic [2:0] c_op_or   = 3'd2;
  localparam logic [2:0] c_op_and  = 3'd3;
  localparam logic [2:0] c_op_xor  = 3'd4;
  localparam logic [2:0] c_op_xnor = 3'd5;
  localparam logic [2:0] c_op_cmp  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_FLAG  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_serial_driver_shreg.sv
`default_nettype none
// ============================================================================
// Module : alu_serial_driver_shreg
// Brief  : WIDTH-bit right shift register, serial-in at MSB, parallel load.
// Rev    : 1.0
// ============================================================================
module alu_serial_driver_shreg
  import alu_serial_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/alu_serial_driver.sv
`default_nettype none
// ============================================================================
// Module : alu_serial_driver
// Brief  : Serialises parallel operands LSB-first into a bit-serial ALU and
//          reassembles the parallel result and end-of-operation flag.
// Rev    : 1.0
// ============================================================================
module alu_serial_driver
  import alu_serial_driver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [OPW-1:0]   op_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             c_out,
  output logic             ser_rst,
  output logic [OPW-1:0]   ser_opcode,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_y,
  input  logic             ser_c
);

  localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_ser_rst;
  logic               r_c;
  logic [OPW-1:0]     r_op;

  logic               w_accept;
  logic               w_shift;
  logic [WIDTH-1:0]   w_a_q;
  logic [WIDTH-1:0]   w_b_q;
  logic [WIDTH-1:0]   w_y_q;
  logic               w_unused;

  assign w_accept = in_valid & (r_state == S_IDLE);
  assign w_shift  = (r_state == S_SHIFT);

  // Operand registers present bit k on their LSB during SHIFT cycle k.
  alu_serial_driver_shreg #(.WIDTH(WIDTH)) u_sh_a (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (w_accept),
    .i_shift(w_shift),
    .i_d    (a_in),
    .i_sin  (1'b0),
    .o_q    (w_a_q)
  );

  alu_serial_driver_shreg #(.WIDTH(WIDTH)) u_sh_b (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (w_accept),
    .i_shift(w_shift),
    .i_d    (b_in),
    .i_sin  (1'b0),
    .o_q    (w_b_q)
  );

  // Result bits enter at the MSB so bit k settles at y[k] after WIDTH shifts.
  alu_serial_driver_shreg #(.WIDTH(WIDTH)) u_sh_y (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (1'b0),
    .i_shift(w_shift),
    .i_d    ('0),
    .i_sin  (ser_y),
    .o_q    (w_y_q)
  );

  assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ser_rst   <= 1'b0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= S_CLR;
            r_in_ready <= 1'b0;
            r_op       <= op_in;
          end
        end
        S_CLR: begin
          r_state   <= S_SHIFT;
          r_ser_rst <= 1'b1;
          r_cnt     <= '0;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_state <= S_FLAG;
          end
        end
        S_FLAG: begin
          r_c         <= ser_c;
          r_ser_rst   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_ser_rst   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign ser_rst    = r_ser_rst;
  assign ser_opcode = r_op;
  assign ser_a      = w_shift & w_a_q[0];
  assign ser_b      = w_shift & w_b_q[0];
  assign y_out      = w_y_q;
  assign c_out      = r_c;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_serial_driver
// Brief  : Directed bench for alu_serial_driver with a bit-serial ALU model.
// Rev    : 1.0
// ============================================================================
module tb_alu_serial_driver;
  import alu_serial_driver_pkg::*;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic [OPW-1:0]   op_in = '0;
  logic             in_ready, out_valid, c_out, ser_rst, ser_a, ser_b, ser_y, ser_c;
  logic [WIDTH-1:0] y_out;
  logic [OPW-1:0]   ser_opcode;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_serial_driver #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_in     (op_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .c_out     (c_out),
    .ser_rst   (ser_rst),
    .ser_opcode(ser_opcode),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_y     (ser_y),
    .ser_c     (ser_c)
  );

  // Bit-serial ALU: one state bit (carry / greater-than / result-nonzero).
  logic m_st, m_y, m_nxt, m_init;
  always_comb begin
    m_y    = 1'b0;
    m_nxt  = m_st;
    m_init = 1'b0;
    case (ser_opcode)
      c_op_add: begin
        m_y   = ser_a ^ ser_b ^ m_st;
        m_nxt = (ser_a & ser_b) | ((ser_a ^ ser_b) & m_st);
      end
      c_op_sub: begin
        m_y    = ser_a ^ ~ser_b ^ m_st;
        m_nxt  = (ser_a & ~ser_b) | ((ser_a ^ ~ser_b) & m_st);
        m_init = 1'b1;
      end
      c_op_or:   begin m_y = ser_a | ser_b;     m_nxt = m_st | m_y; end
      c_op_and:  begin m_y = ser_a & ser_b;     m_nxt = m_st | m_y; end
      c_op_xor:  begin m_y = ser_a ^ ser_b;     m_nxt = m_st | m_y; end
      c_op_xnor: begin m_y = ~(ser_a ^ ser_b);  m_nxt = m_st | m_y; end
      c_op_cmp: begin
        m_y = ser_a ^ ser_b;
        if (ser_a & ~ser_b)      m_nxt = 1'b1;
        else if (~ser_a & ser_b) m_nxt = 1'b0;
      end
      default: begin
        m_y   = 1'b0;
        m_nxt = m_st;
      end
    endcase
  end

  always @(posedge clk) m_st <= !ser_rst ? m_init : m_nxt;

  assign ser_y = m_y;
  assign ser_c = m_st;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] y, output logic c);
    logic [7:0] sa, sb;
    logic       ctl_ok;
    int         lat;
    sa     = '0;
    sb     = '0;
    ctl_ok = 1'b1;
    check_eq($sformatf("idle_ready op%0d", op), 32'(in_ready), 32'd1);
    in_valid = 1'b1; a_in = a; b_in = b; op_in = op;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
    lat = 0;
    if (ser_rst !== 1'b0 || in_ready !== 1'b0 || ser_opcode !== op) ctl_ok = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 1 && lat <= 8) begin
        sa = {ser_a, sa[7:1]};
        sb = {ser_b, sb[7:1]};
        if (ser_rst !== 1'b1) ctl_ok = 1'b0;
      end
      if (lat == 9 && (ser_rst !== 1'b1 || ser_a !== 1'b0 || ser_b !== 1'b0)) ctl_ok = 1'b0;
      if (ser_opcode !== op) ctl_ok = 1'b0;
    end
    if (ser_rst !== 1'b0) ctl_ok = 1'b0;
    // Accept edge T, out_valid first seen after edge T+WIDTH+2.
    check_eq($sformatf("latency op%0d", op), 32'(lat), 32'd10);
    check_eq($sformatf("ser_a op%0d", op), 32'(sa), 32'(a));
    check_eq($sformatf("ser_b op%0d", op), 32'(sb), 32'(b));
    check_eq($sformatf("ctl op%0d", op), 32'(ctl_ok), 32'd1);
    y = y_out;
    c = c_out;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("release", 32'({out_valid, in_ready}), 32'b01);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       c;
    bit         cy;
    bit         cc;
  } vec_t;

  vec_t tbl [0:7];

  initial begin
    logic [7:0] y;
    logic       c;
    bit         seen;

    tbl = '{
      '{c_op_add,  8'd200, 8'd100, 8'd44,  1'b1, 1'b1, 1'b1},
      '{c_op_sub,  8'd5,   8'd7,   8'd254, 1'b0, 1'b1, 1'b0},
      '{c_op_and,  8'hFF,  8'h0F,  8'h0F,  1'b1, 1'b1, 1'b1},
      '{c_op_or,   8'h00,  8'h00,  8'h00,  1'b0, 1'b1, 1'b1},
      '{c_op_cmp,  8'd3,   8'd2,   8'h00,  1'b1, 1'b0, 1'b1},
      '{c_op_cmp,  8'd2,   8'd3,   8'h00,  1'b0, 1'b0, 1'b1},
      '{c_op_xor,  8'hA5,  8'h3C,  8'h99,  1'b1, 1'b1, 1'b1},
      '{3'd7,      8'h5A,  8'hC3,  8'h00,  1'b0, 1'b0, 1'b0}
    };

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst y_out", 32'(y_out), 32'd0);
    check_eq("rst c_out", 32'(c_out), 32'd0);
    check_eq("rst ser", 32'({ser_rst, ser_a, ser_b, ser_opcode}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, y, c);
      if (tbl[i].cy) check_eq($sformatf("y vec%0d", i), 32'(y), 32'(tbl[i].y));
      if (tbl[i].cc) check_eq($sformatf("c vec%0d", i), 32'(c), 32'(tbl[i].c));
      release_op();
    end

    // Backpressure in DONE while a new request is offered.
    run_op(c_op_add, 8'd200, 8'd100, y, c);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a_in = 8'd1; b_in = 8'd1; op_in = c_op_add;
      @(posedge clk); #1;
      check_eq($sformatf("hold cyc%0d", k), 32'({out_valid, in_ready, c_out, y_out}),
               32'({1'b1, 1'b0, 1'b1, 8'd44}));
    end
    in_valid = 1'b0;
    release_op();
    repeat (3) @(posedge clk);
    #1 check_eq("no ghost op", 32'({in_ready, out_valid, ser_rst}), 32'b100);

    // Reset during SHIFT cycle 4.
    in_valid = 1'b1; a_in = 8'd200; b_in = 8'd100; op_in = c_op_add;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_eq("in shift", 32'(ser_rst), 32'd1);
    rst = 1'b0;
    #1 check_eq("rst mid shift", 32'({in_ready, out_valid, ser_rst, ser_a, ser_b, y_out}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
    @(posedge clk); #1 rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("no valid after rst", 32'(seen), 32'd0);
    run_op(c_op_add, 8'd1, 8'd1, y, c);
    check_eq("add 1+1 y", 32'(y), 32'd2);
    check_eq("add 1+1 c", 32'(c), 32'd0);
    release_op();

    // Reset while holding a result in DONE; XNOR flag must be from the shift.
    run_op(c_op_xnor, 8'hF0, 8'h0F, y, c);
    check_eq("xnor y", 32'(y), 32'h00);
    check_eq("xnor c", 32'(c), 32'd0);
    rst = 1'b0;
    #1 check_eq("rst in done", 32'({out_valid, in_ready, c_out, y_out}),
                32'({1'b0, 1'b1, 1'b0, 8'd0}));
    @(posedge clk); #1 rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_eq("no valid after done rst", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
